app_stream_rx: RTL and testbench
================================

# app_stream_rx

Receive-side framer for the application injection stream. Consumes the flat flit stream produced by the application source (descriptor header, mapping/tag pairs, graph descriptor, then per-task headers and binaries). Labels every flit with its field type and marks application boundaries. Forwards the labelled stream to the packetizer over the same tx/credit handshake.

## Interface
- FLIT_SIZE, 32, flit width in bits (≥ 16).
- FIFO_DEPTH, 4, input buffer depth in flits; power of two, ≥ 2.

- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- rx_i  in  1  input flit valid.
- credit_o  out  1  input ready; transfer when rx_i && credit_o at an edge.
- data_i  in  FLIT_SIZE  input flit.
- tx_o  out  1  output flit valid.
- credit_i  in  1  downstream ready; transfer when tx_o && credit_i at an edge.
- data_o  out  FLIT_SIZE  output flit, unmodified copy of input.
- field_o  out  4  field code of data_o (see Operation).
- last_o  out  1  data_o is the final flit of the current application.
- app_done_o  out  1  one-cycle pulse in the cycle after the last flit transfers out.
- err_o  out  1  sticky framing error flag.

## Operation
- Input FIFO of FIFO_DEPTH. credit_o = !full, combinational from the occupancy counter. Write and read in the same cycle are allowed when full: credit_o stays low that cycle, with no bypass.
- Parser FSM pops the FIFO head into a single output register when the register is empty or transferring this cycle. The field code equals the state encoding:
  - 0 DSIZE: latch descr_rem. Next TCNT.
  - 1 TCNT: latch task_cnt, task_idx=0. Next MAP, or DESCR if task_cnt=0.
  - 2 MAP: next TAG.
  - 3 TAG: the value must be all-ones, otherwise set err_o; the flit is still forwarded. task_idx++. Next MAP if task_idx<task_cnt. Otherwise next DESCR, or TEXT if descr_rem=0.
  - 4 DESCR: descr_rem--. When it reaches 0, next TEXT, task_idx=0. If task_cnt=0, this is the application end (goes to DSIZE).
  - 5 TEXT: bin_sum=data.
  - 6 DATA: bin_sum+=data.
  - 7 BSS.
  - 8 ENTRY: bin_rem=bin_sum>>2. Next BIN, or end-of-task if bin_rem=0.
  - 9 BIN: bin_rem--. End-of-task when it reaches 0.
  - End-of-task: task_idx++. Next TEXT if task_idx<task_cnt, else application end → DSIZE.
- Edge cases that end the application:
  - task_cnt=0 and descr_size=0: the TCNT flit is last. Next DSIZE.
  - task_cnt=0 and descr_size>0: the last DESCR flit is last.
- bin_sum is FLIT_SIZE+1 bits with no wrap. Byte counts not a multiple of 4 truncate to whole words. bin_rem is FLIT_SIZE bits.
- last_o is set with the flit that ends the application. app_done_o pulses the cycle after that flit transfers.
- err_o clears only on reset.

## Timing
- Reset (any cycle, including mid-application) has these effects:
  - FIFO flushed and FSM → DSIZE.
  - All counters 0.
  - tx_o=0, data_o=0, field_o=0, last_o=0, app_done_o=0, err_o=0, credit_o=0 during the reset cycle, then 1 after.
- Latency: a flit written at edge k into an empty FIFO with an empty output register drives tx_o/data_o from edge k+1.
- Throughput: 1 flit/cycle sustained with credit_i held high and rx_i held high.
- Output stability: while tx_o && !credit_i, data_o/field_o/last_o are held stable.
- No input flit is dropped or duplicated under any credit_i pattern.

## Test plan
- Full application, 1 task: input stream 2,1,0x0101,0xFFFFFFFF, descr 7,9, text 8, data 4, bss 0, entry 0x100, 3 binary words.
  - Expected field_o: 0,1,2,3,4,4,5,6,7,8,9,9,9.
  - last_o only on the 3rd BIN flit; app_done_o pulses once; err_o=0.
- Backpressure: same stream with credit_i toggling 1-in-3.
  - Identical output sequence.
  - credit_o low exactly when FIFO occupancy=FIFO_DEPTH.
- Empty application: input 0,0.
  - TCNT flit carries last_o=1.
  - Next flit is labelled field 0.
- Bad tag: tag 0x00000000.
  - err_o rises the cycle after the TAG flit is popped and remains set.
  - Parsing continues normally.
- Zero binary: text 0, data 0.
  - ENTRY flit is last; no BIN field emitted.
- Reset mid-BIN: assert rst_i for 1 cycle.
  - Outputs reach reset values; credit_o=1 afterwards.
  - A new stream starting with DSIZE parses correctly from field 0.

Source files
------------

// File: rtl/app_stream_rx_if.sv
// Flit stream handshake (tx/credit/data) shared by the application source,
// the receive framer and the packetizer.
interface app_stream_rx_if #(
   parameter int unsigned FLIT_SIZE = 32
);
   logic                 tx;
   logic                 credit;
   logic [FLIT_SIZE-1:0] data;

   modport master (output tx, output data, input credit);
   modport slave  (input tx, input data, output credit);
endinterface

// File: rtl/app_stream_rx.sv
// Receive-side framer: buffers the application injection stream, labels each
// flit with its field code and flags the final flit of every application.
module app_stream_rx #(
   parameter int unsigned FLIT_SIZE  = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   app_stream_rx_if.slave  rx,
   app_stream_rx_if.master tx,
   output logic [3:0]      field_o,
   output logic            last_o,
   output logic            app_done_o,
   output logic            err_o
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [3:0] {
      S_DSIZE = 4'd0,
      S_TCNT  = 4'd1,
      S_MAP   = 4'd2,
      S_TAG   = 4'd3,
      S_DESCR = 4'd4,
      S_TEXT  = 4'd5,
      S_DATA  = 4'd6,
      S_BSS   = 4'd7,
      S_ENTRY = 4'd8,
      S_BIN   = 4'd9
   } state_t;

   logic [FLIT_SIZE-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW:0]          count;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic [FLIT_SIZE-1:0] head;

   logic                 out_valid;
   logic [FLIT_SIZE-1:0] out_data;

   state_t               state, state_n;
   logic [FLIT_SIZE-1:0] descr_rem, descr_rem_n;
   logic [FLIT_SIZE-1:0] task_cnt, task_cnt_n;
   logic [FLIT_SIZE-1:0] task_idx, task_idx_n;
   logic [FLIT_SIZE-1:0] bin_rem, bin_rem_n;
   logic [FLIT_SIZE:0]   bin_sum, bin_sum_n;
   logic [FLIT_SIZE-1:0] idx_inc;
   logic                 err_n;
   logic                 app_end;
   logic                 task_end;

   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign rx.credit = !rst_i && !full;
   assign push      = rx.tx && rx.credit;
   assign pop       = !empty && (!out_valid || tx.credit);
   assign head      = mem[rd_ptr];

   assign tx.tx   = out_valid;
   assign tx.data = out_data;

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= rx.data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Next-state logic evaluates the FIFO head; it only takes effect on a pop.
   always_comb begin
      state_n     = state;
      descr_rem_n = descr_rem;
      task_cnt_n  = task_cnt;
      task_idx_n  = task_idx;
      bin_rem_n   = bin_rem;
      bin_sum_n   = bin_sum;
      err_n       = err_o;
      app_end     = 1'b0;
      task_end    = 1'b0;
      idx_inc     = task_idx + FLIT_SIZE'(1);
      unique case (state)
         S_DSIZE: begin
            descr_rem_n = head;
            state_n     = S_TCNT;
         end
         S_TCNT: begin
            task_cnt_n = head;
            task_idx_n = '0;
            if (head != '0) begin
               state_n = S_MAP;
            end else if (descr_rem != '0) begin
               state_n = S_DESCR;
            end else begin
               app_end = 1'b1;
            end
         end
         S_MAP: begin
            state_n = S_TAG;
         end
         S_TAG: begin
            if (head != '1) begin
               err_n = 1'b1;
            end
            task_idx_n = idx_inc;
            if (idx_inc < task_cnt) begin
               state_n = S_MAP;
            end else if (descr_rem != '0) begin
               state_n = S_DESCR;
            end else begin
               state_n    = S_TEXT;
               task_idx_n = '0;
            end
         end
         S_DESCR: begin
            descr_rem_n = descr_rem - FLIT_SIZE'(1);
            if (descr_rem == FLIT_SIZE'(1)) begin
               if (task_cnt == '0) begin
                  app_end = 1'b1;
               end else begin
                  state_n    = S_TEXT;
                  task_idx_n = '0;
               end
            end
         end
         S_TEXT: begin
            bin_sum_n = {1'b0, head};
            state_n   = S_DATA;
         end
         S_DATA: begin
            bin_sum_n = bin_sum + {1'b0, head};
            state_n   = S_BSS;
         end
         S_BSS: begin
            state_n = S_ENTRY;
         end
         S_ENTRY: begin
            bin_rem_n = FLIT_SIZE'(bin_sum >> 2);
            if (bin_sum[FLIT_SIZE:2] == '0) begin
               task_end = 1'b1;
            end else begin
               state_n = S_BIN;
            end
         end
         S_BIN: begin
            bin_rem_n = bin_rem - FLIT_SIZE'(1);
            if (bin_rem == FLIT_SIZE'(1)) begin
               task_end = 1'b1;
            end
         end
         default: begin
            state_n = S_DSIZE;
         end
      endcase
      if (task_end) begin
         task_idx_n = idx_inc;
         if (idx_inc < task_cnt) begin
            state_n = S_TEXT;
         end else begin
            app_end = 1'b1;
         end
      end
      if (app_end) begin
         state_n = S_DSIZE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= S_DSIZE;
         descr_rem  <= '0;
         task_cnt   <= '0;
         task_idx   <= '0;
         bin_rem    <= '0;
         bin_sum    <= '0;
         err_o      <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         field_o    <= '0;
         last_o     <= 1'b0;
         app_done_o <= 1'b0;
      end else begin
         app_done_o <= out_valid && tx.credit && last_o;
         if (pop) begin
            state     <= state_n;
            descr_rem <= descr_rem_n;
            task_cnt  <= task_cnt_n;
            task_idx  <= task_idx_n;
            bin_rem   <= bin_rem_n;
            bin_sum   <= bin_sum_n;
            err_o     <= err_n;
            out_valid <= 1'b1;
            out_data  <= head;
            field_o   <= state;
            last_o    <= app_end;
         end else if (tx.credit) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_app_stream_rx.sv
// Randomised scoreboard bench for app_stream_rx: applications are built from
// high-level parameters, and each flit's label is known at construction time.
`timescale 1ns/1ps
module tb_app_stream_rx;

   localparam int unsigned FS    = 32;
   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] field;
   logic       last;
   logic       app_done;
   logic       err;

   app_stream_rx_if #(.FLIT_SIZE(FS)) rx_bus ();
   app_stream_rx_if #(.FLIT_SIZE(FS)) tx_bus ();

   app_stream_rx #(.FLIT_SIZE(FS), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .rx        (rx_bus),
      .tx        (tx_bus),
      .field_o   (field),
      .last_o    (last),
      .app_done_o(app_done),
      .err_o     (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  f;
      logic        l;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] stream_d[$];
   bit          stream_bad[$];
   int unsigned drv_idx = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned cmode = 1;
   int unsigned gap_pct = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic push(logic [31:0] d, logic [3:0] f, bit l, bit b);
      exp_t e;
      e.d = d;
      e.f = f;
      e.l = l;
      stream_d.push_back(d);
      stream_bad.push_back(b);
      exp_q.push_back(e);
   endtask

   // Worked example application; tag value selects a good or bad tag.
   task automatic gen_directed(logic [31:0] tag);
      logic [31:0] d[13];
      logic [3:0]  f[13];
      d = '{32'd2, 32'd1, 32'h101, tag, 32'd7, 32'd9, 32'd8, 32'd4, 32'd0,
            32'h100, 32'h11, 32'h22, 32'h33};
      f = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
            4'd9, 4'd9, 4'd9};
      for (int i = 0; i < 13; i++) begin
         push(d[i], f[i], i == 12, (i == 3) && (tag != '1));
      end
   endtask

   // Negative tb/db pick random byte counts per task; bad selects a bad tag.
   task automatic gen_app(int unsigned dsize, int unsigned tcnt, int bad, int tb, int db);
      int unsigned words;
      int unsigned tbytes;
      int unsigned dbytes;
      logic [31:0] tag;
      push(dsize, 4'd0, 1'b0, 1'b0);
      push(tcnt, 4'd1, (tcnt == 0) && (dsize == 0), 1'b0);
      for (int t = 0; t < int'(tcnt); t++) begin
         push($urandom, 4'd2, 1'b0, 1'b0);
         tag = (t == bad) ? ($urandom & 32'hFFFF_FFFE) : 32'hFFFF_FFFF;
         push(tag, 4'd3, 1'b0, t == bad);
      end
      for (int i = 0; i < int'(dsize); i++) begin
         push($urandom, 4'd4, (tcnt == 0) && (i == int'(dsize) - 1), 1'b0);
      end
      for (int t = 0; t < int'(tcnt); t++) begin
         tbytes = (tb < 0) ? $urandom_range(0, 48) : tb;
         dbytes = (db < 0) ? $urandom_range(0, 48) : db;
         words  = (tbytes + dbytes) / 4;
         push(tbytes, 4'd5, 1'b0, 1'b0);
         push(dbytes, 4'd6, 1'b0, 1'b0);
         push($urandom, 4'd7, 1'b0, 1'b0);
         push($urandom, 4'd8, (t == int'(tcnt) - 1) && (words == 0), 1'b0);
         for (int w = 0; w < int'(words); w++) begin
            push($urandom, 4'd9, (t == int'(tcnt) - 1) && (w == int'(words) - 1), 1'b0);
         end
      end
   endtask

   task automatic send_upto(int unsigned n);
      int unsigned w;
      bit          acc;
      while (drv_idx < n) begin
         if ($urandom_range(0, 99) < gap_pct) begin
            rx_bus.tx = 1'b0;
            @(posedge clk); #1;
         end else begin
            rx_bus.tx   = 1'b1;
            rx_bus.data = stream_d[drv_idx];
            w   = 0;
            acc = 1'b0;
            while (!acc) begin
               @(negedge clk);
               acc = rx_bus.credit;
               @(posedge clk); #1;
               w++;
               if (!acc && w > 500) begin
                  chk("drive_timeout", 32'd1, 32'd0);
                  rx_bus.tx = 1'b0;
                  drv_idx   = n;
                  return;
               end
            end
            drv_idx++;
         end
      end
      rx_bus.tx = 1'b0;
   endtask

   task automatic drain();
      int unsigned w;
      w = 0;
      while (exp_q.size() != 0 && w < 4000) begin
         @(posedge clk);
         w++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(string tag);
      chk({tag, "_tx"}, 32'(tx_bus.tx), 32'd0);
      chk({tag, "_data"}, tx_bus.data, 32'd0);
      chk({tag, "_field"}, 32'(field), 32'd0);
      chk({tag, "_last"}, 32'(last), 32'd0);
      chk({tag, "_app_done"}, 32'(app_done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_credit"}, 32'(rx_bus.credit), 32'd0);
   endtask

   // Downstream credit pattern generator.
   int unsigned ccnt = 0;
   initial begin
      tx_bus.credit = 1'b1;
      forever begin
         @(posedge clk); #1;
         ccnt++;
         case (cmode)
            0:       tx_bus.credit = 1'b0;
            1:       tx_bus.credit = 1'b1;
            2:       tx_bus.credit = (ccnt % 3 == 0);
            default: tx_bus.credit = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: cycle-level occupancy/err model plus in-order scoreboard.
   int unsigned occ = 0;
   int unsigned pidx = 0;
   bit          ofull = 0;
   bit          err_e = 0;
   bit          done_e = 0;
   bit          hold = 0;
   logic [31:0] hd;
   logic [3:0]  hf;
   logic        hl;
   always @(negedge clk) begin
      bit   wr;
      bit   rd;
      bit   xfer_last;
      exp_t e;
      xfer_last = 1'b0;
      if (rst) begin
         occ    = 0;
         ofull  = 1'b0;
         err_e  = 1'b0;
         done_e = 1'b0;
         hold   = 1'b0;
         pidx   = drv_idx;
      end else begin
         chk("credit", 32'(rx_bus.credit), 32'(occ != DEPTH));
         chk("tx_valid", 32'(tx_bus.tx), 32'(ofull));
         chk("app_done", 32'(app_done), 32'(done_e));
         chk("err", 32'(err), 32'(err_e));
         if (hold) begin
            chk("hold_data", tx_bus.data, hd);
            chk("hold_field", 32'(field), 32'(hf));
            chk("hold_last", 32'(last), 32'(hl));
         end
         if (tx_bus.tx && tx_bus.credit) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", tx_bus.data, e.d);
               chk("out_field", 32'(field), 32'(e.f));
               chk("out_last", 32'(last), 32'(e.l));
               xfer_last = e.l;
            end
         end
         wr     = rx_bus.tx && rx_bus.credit;
         rd     = (occ > 0) && (!ofull || tx_bus.credit);
         done_e = ofull && tx_bus.credit && xfer_last;
         hold   = tx_bus.tx && !tx_bus.credit;
         hd     = tx_bus.data;
         hf     = field;
         hl     = last;
         if (rd) begin
            if (pidx < stream_bad.size() && stream_bad[pidx]) err_e = 1'b1;
            pidx++;
         end
         ofull = rd ? 1'b1 : (tx_bus.credit ? 1'b0 : ofull);
         occ   = occ + (wr ? 1 : 0) - (rd ? 1 : 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      rx_bus.tx   = 1'b0;
      rx_bus.data = '0;
      rst         = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("por");
      rst = 1'b0;
      #1;
      chk("credit_after_por", 32'(rx_bus.credit), 32'd1);

      // Worked example at full rate, then under 1-in-3 credit.
      cmode = 1; gap_pct = 0;
      gen_directed(32'hFFFF_FFFF);
      send_upto(stream_d.size());
      drain();
      cmode = 2;
      gen_directed(32'hFFFF_FFFF);
      send_upto(stream_d.size());
      drain();
      chk("err_clean", 32'(err), 32'd0);

      // Empty application followed by a normal one.
      cmode = 3; gap_pct = 20;
      gen_app(0, 0, -1, 0, 0);
      gen_app(2, 1, -1, -1, -1);
      gen_app(3, 0, -1, 0, 0);
      send_upto(stream_d.size());
      drain();

      // Bad tag: flagged, still forwarded, parsing continues.
      cmode = 1; gap_pct = 0;
      gen_directed(32'h0000_0000);
      gen_app(1, 2, -1, -1, -1);
      send_upto(stream_d.size());
      drain();
      chk("err_sticky", 32'(err), 32'd1);

      // Zero-length and sub-word binaries.
      cmode = 2; gap_pct = 10;
      gen_app(0, 1, -1, 0, 0);
      gen_app(3, 2, -1, 3, 0);
      send_upto(stream_d.size());
      drain();

      for (int i = 0; i < 10; i++) begin
         cmode   = $urandom_range(1, 3);
         gap_pct = $urandom_range(0, 40);
         gen_app($urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1, -1, -1);
         send_upto(stream_d.size());
         drain();
      end

      // Reset in the middle of a binary.
      cmode = 1; gap_pct = 0;
      base = stream_d.size();
      gen_app(0, 1, -1, 40, 40);
      send_upto(base + 11);
      cmode = 0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_valid", 32'(tx_bus.tx), 32'd1);
      chk("pre_rst_field", 32'(field), 32'd9);
      @(posedge clk); #1;
      while (stream_d.size() > drv_idx) begin
         void'(stream_d.pop_back());
         void'(stream_bad.pop_back());
      end
      exp_q.delete();
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_vals("mid_rst");
      rst = 1'b0;
      #1;
      chk("credit_after_rst", 32'(rx_bus.credit), 32'd1);

      for (int i = 0; i < 4; i++) begin
         cmode   = $urandom_range(1, 3);
         gap_pct = $urandom_range(0, 30);
         gen_app($urandom_range(0, 2), $urandom_range(1, 2), -1, -1, -1);
         send_upto(stream_d.size());
         drain();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
